// File: rtl/mem_xfer_sequencer_if.sv
interface mem_xfer_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_en;
  logic              mem_rw;
  logic [1:0]        mem_size;
  logic [31:0]       mem_rdata;
  logic              mem_moc;

  modport master (
    output mem_addr, mem_wdata, mem_en, mem_rw, mem_size,
    input  mem_rdata, mem_moc
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_en, mem_rw, mem_size,
    output mem_rdata, mem_moc
  );
endinterface

// File: rtl/mem_xfer_sequencer.sv
module mem_xfer_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fetch,
  input  logic [31:0]       ir,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [63:0]       load_data,
  mem_xfer_sequencer_if.master mem
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC1,
    S_ACC2,
    S_FIN,
    S_ERR
  } state_t;

  typedef enum logic [1:0] {
    K_BYTE  = 2'b00,
    K_HALF  = 2'b01,
    K_WORD  = 2'b10,
    K_DWORD = 2'b11
  } kind_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit          TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_d, done_d, err_d;
  logic [1:0]        err_code_d;
  logic [63:0]       load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              en_q, en_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       word1_q, word1_d;
  logic [31:0]       hi_q, hi_d;
  kind_t             kind_q, kind_d;
  logic              sgn_q, sgn_d;

  logic              dec_legal;
  logic              dec_load;
  logic              dec_signed;
  kind_t             dec_kind;
  logic              dec_aligned;
  logic [31:0]       dec_wdata;
  logic [63:0]       ext_data;

  logic unused_ir_bits;
  assign unused_ir_bits = ^{ir[31:28], ir[24:23], ir[21], ir[19:8], ir[3:0]};

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_en    = en_q;
  assign mem.mem_rw    = rw_q;
  assign mem.mem_size  = size_q;

  always_comb begin
    dec_legal  = 1'b1;
    dec_load   = 1'b1;
    dec_signed = 1'b0;
    dec_kind   = K_WORD;
    if (!fetch) begin
      if (ir[27:26] == 2'b01) begin
        dec_load = ir[20];
        dec_kind = ir[22] ? K_BYTE : K_WORD;
      end else if (ir[27:25] == 3'b000 && ir[7] && ir[4] && ir[6:5] != 2'b00) begin
        if (ir[20]) begin
          dec_kind   = (ir[6:5] == 2'b10) ? K_BYTE : K_HALF;
          dec_signed = ir[6];
        end else begin
          dec_kind = (ir[6:5] == 2'b01) ? K_HALF : K_DWORD;
          dec_load = (ir[6:5] == 2'b10);
        end
      end else begin
        dec_legal = 1'b0;
      end
    end
  end

  always_comb begin
    case (dec_kind)
      K_BYTE:  dec_aligned = 1'b1;
      K_HALF:  dec_aligned = ~addr[0];
      K_WORD:  dec_aligned = (addr[1:0] == 2'b00);
      default: dec_aligned = (addr[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    case (dec_kind)
      K_BYTE:  dec_wdata = {24'b0, store_data[7:0]};
      K_HALF:  dec_wdata = {16'b0, store_data[15:0]};
      default: dec_wdata = store_data[31:0];
    endcase
  end

  always_comb begin
    case (kind_q)
      K_BYTE:  ext_data = sgn_q ? {{56{mem.mem_rdata[7]}}, mem.mem_rdata[7:0]}
                                : {56'b0, mem.mem_rdata[7:0]};
      K_HALF:  ext_data = sgn_q ? {{48{mem.mem_rdata[15]}}, mem.mem_rdata[15:0]}
                                : {48'b0, mem.mem_rdata[15:0]};
      K_WORD:  ext_data = {32'b0, mem.mem_rdata};
      default: ext_data = {mem.mem_rdata, word1_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code;
    load_d     = load_data;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    en_d       = en_q;
    rw_d       = rw_q;
    size_d     = size_q;
    word1_d    = word1_q;
    hi_d       = hi_q;
    kind_d     = kind_q;
    sgn_d      = sgn_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          err_code_d = '0;
          if (!dec_legal) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else if (!dec_aligned) begin
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            state_d = S_ACC1;
            busy_d  = 1'b1;
            en_d    = 1'b1;
            addr_d  = addr;
            rw_d    = dec_load;
            size_d  = (dec_kind == K_DWORD) ? 2'b10 : dec_kind;
            wdata_d = dec_wdata;
            hi_d    = store_data[63:32];
            kind_d  = dec_kind;
            sgn_d   = dec_signed;
          end
        end
      end
      S_ACC1, S_ACC2: begin
        if (mem.mem_moc) begin
          cnt_d = '0;
          if (state_q == S_ACC1) begin
            word1_d = mem.mem_rdata;
          end
          if (state_q == S_ACC1 && kind_q == K_DWORD) begin
            state_d = S_ACC2;
            addr_d  = addr_q + ADDR_W'(4);
            wdata_d = hi_q;
          end else begin
            state_d = S_FIN;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (rw_q) begin
              load_d = ext_data;
            end
          end
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          // cnt holds the number of completed idle cycles, so the limit is one short
          state_d    = S_ERR;
          cnt_d      = '0;
          en_d       = 1'b0;
          busy_d     = 1'b0;
          err_d      = 1'b1;
          err_code_d = 2'b11;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FIN, S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_code  <= '0;
      load_data <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      en_q      <= 1'b0;
      rw_q      <= 1'b0;
      size_q    <= '0;
      word1_q   <= '0;
      hi_q      <= '0;
      kind_q    <= K_BYTE;
      sgn_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      err_code  <= err_code_d;
      load_data <= load_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      en_q      <= en_d;
      rw_q      <= rw_d;
      size_q    <= size_d;
      word1_q   <= word1_d;
      hi_q      <= hi_d;
      kind_q    <= kind_d;
      sgn_q     <= sgn_d;
    end
  end

endmodule
